// File: rtl/onehot_decoder_pipe.sv
// ---------------------------------------------------------------------------
// onehot_decoder_pipe
//
// Registered index decoder with a valid/ready handshake on both sides. Each
// accepted index is decoded immediately into a one-hot code (in_mode = 0) or
// a thermometer code (in_mode = 1). The result is stored in a 2-entry FIFO
// whose head drives the outputs. Indices at or above OUT_W produce a zero
// code with out_err set.
//
// Ports:
//   clock      rising-edge clock for all state
//   reset      asynchronous, active-low reset
//   in_valid   in_index / in_mode are valid
//   in_ready   an input transfer can happen this cycle (state-only)
//   in_index   index to decode (IN_W bits)
//   in_mode    0 = one-hot, 1 = thermometer
//   out_valid  out_data / out_err are valid
//   out_ready  downstream accepts the head entry this cycle
//   out_data   decoded code of the head entry, 0 when idle
//   out_err    head entry had an out-of-range index, 0 when idle
//   occupancy  number of entries held (0..2)
// ---------------------------------------------------------------------------
module onehot_decoder_pipe #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_index,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err,
    output logic [1:0]       occupancy
);

    // Largest code width the index can address.
    localparam longint MAX_OUT_W = longint'(1) << IN_W;

    generate
        if (IN_W < 1 || IN_W > 31 || OUT_W < 2 || OUT_W > MAX_OUT_W) begin : g_bad_params
            $error("onehot_decoder_pipe: OUT_W must be in 2..2**IN_W");
        end
    endgenerate

    typedef struct packed {
        logic             err;
        logic [OUT_W-1:0] code;
    } entry_t;

    entry_t     mem [2];
    entry_t     dec;
    logic       head;
    logic       tail;
    logic [1:0] count;
    logic       push;
    logic       pop;
    int         idx;

    // ------------------------------------------------------------------
    // Decode at accept time so each entry carries its own mode.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        dec = '0;
        idx = int'(in_index);
        if (idx >= OUT_W) begin
            dec.err = 1'b1;
        end else begin
            for (int i = 0; i < OUT_W; i++) begin
                dec.code[i] = in_mode ? (i <= idx) : (i == idx);
            end
        end
    end

    // ready depends only on stored occupancy and reset, never on out_ready
    assign in_ready  = (count != 2'd2) && reset;
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Pointers and occupancy.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values of the others.
            if (push) tail <= ~tail;
            if (pop)  head <= ~head;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; a slot is only observed after it has been
    // written, and the outputs below are gated by out_valid.
    always_ff @(posedge clock) begin
        if (push) mem[tail] <= dec;
    end

    // Idle outputs are forced low rather than showing stale slot contents.
    assign out_data  = out_valid ? mem[head].code : '0;
    assign out_err   = out_valid ? mem[head].err  : 1'b0;
    assign occupancy = count;

endmodule

// File: doc/onehot_decoder_pipe.md
Name: onehot_decoder_pipe

Overview:
Parametrised, registered successor to the fixed 3-to-8 combinational decoder. It accepts an index through a valid/ready handshake and produces either a one-hot or a thermometer code of OUT_W bits. An out-of-range index raises an error flag instead of producing a code. A 2-entry output buffer lets it sit between pipeline stages without combinational ready paths.

Parameters:
IN_W, 3, width of the input index.
OUT_W, 8, width of the decoded output; legal range 2..2^IN_W. Elaboration fails outside this range.

Ports:
clock  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
in_valid  input  1  in_index/in_mode are valid.
in_ready  output  1  block can accept a transaction this cycle.
in_index  input  IN_W  index to decode.
in_mode  input  1  0 = one-hot, 1 = thermometer.
out_valid  output  1  out_data/out_err are valid.
out_ready  input  1  downstream accepts this cycle.
out_data  output  OUT_W  decoded code.
out_err  output  1  index was >= OUT_W; out_data is 0 for that entry.
occupancy  output  2  number of entries held (0..2).

Behaviour:
- Transfer rules: input transfer when in_valid && in_ready at a rising edge. Output transfer when out_valid && out_ready at a rising edge.
- Decode, computed at accept time and stored per entry with the entry's own in_mode:
  - one-hot: out_data[i] = (i == in_index).
  - thermometer: out_data[i] = (i <= in_index).
  - in_index >= OUT_W: out_data = 0 and out_err = 1, in either mode. This includes indices that cannot reach OUT_W when OUT_W < 2^IN_W.
- Storage: 2-entry FIFO, head drives the outputs.
  - in_ready = (occupancy != 2) and reset deasserted. It is a registered/state-only function and never depends combinationally on out_ready.
- Latency: a transaction accepted at edge N appears on the outputs after edge N when the buffer was empty. It is never presented in the cycle it is accepted.
- Occupancy updates:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle with occupancy 1: stays 1. The new entry becomes head after the old head leaves.
  - occupancy 2: no push possible; a pop gives 1.
- Stability: while out_valid=1 and out_ready=0, out_data and out_err hold stable and out_valid stays 1.
- Ordering: strict FIFO. No entry is dropped or duplicated.
- Idle outputs: when out_valid=0, out_data=0 and out_err=0. They are driven low, not held at stale values.
- Reset, asserted asynchronously: immediately out_valid=0, out_data=0, out_err=0, occupancy=0, in_ready=0. Buffered entries are discarded, including mid-handshake. in_ready rises to 1 in the first cycle after deassertion. Deassertion is synchronised externally.
- Mode is sampled per transaction. A mode change between back-to-back transactions takes effect exactly on the next accepted entry.
- With IN_W=3, OUT_W=8, one-hot mode, each output code is bit-identical to the legacy 3-to-8 decoder for every index.

Test Plan:
- Reset: hold reset=0 with in_valid=1 → out_valid=0, out_data=0x00, in_ready=0, occupancy=0. Release reset → in_ready=1 next cycle.
- One-hot sweep (IN_W=3, OUT_W=8), out_ready=1: indices 0..7 back-to-back → out_data 0x01, 0x02, 0x04 … 0x80, each one cycle after accept. Throughput is 1 per cycle, out_err=0 throughout.
- Thermometer: in_mode=1, in_index=3 → out_data=0x0F. in_index=0 → 0x01. in_index=7 → 0xFF.
- Out-of-range (IN_W=3, OUT_W=6): in_index=6 → out_data=0x00, out_err=1. The following in_index=5 → 0x20, out_err=0.
- Backpressure: out_ready=0, push indices 2 then 4 → occupancy=2, in_ready=0, out_data held at 0x04. Third in_valid is not accepted. Raise out_ready → 0x04 then 0x10, occupancy 2→1→0.
- Reset mid-stream: occupancy=2, assert reset for one cycle → all outputs cleared at once. After release, the first new index 1 gives 0x02 with no stale entries emitted.
